// File: rtl/rev_datapath_seq_if.sv
// Command/result bus between the instruction sequencer (master) and the
// reversible datapath (slave).
interface rev_datapath_seq_if #(
  parameter int WIDTH  = 12,
  parameter int NREG   = 4,
  parameter int ADDR_W = 12
);
  localparam int RW = $clog2(NREG);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        op;
  logic              dir;
  logic [RW-1:0]     rd;
  logic [RW-1:0]     rs;
  logic              cin;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic [ADDR_W-1:0] addr_out;
  logic              ovf;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, op, dir, rd, rs, cin, data_in,
    input  cmd_ready, data_out, addr_out, ovf, done, err
  );

  modport slave (
    input  cmd_valid, op, dir, rd, rs, cin, data_in,
    output cmd_ready, data_out, addr_out, ovf, done, err
  );
endinterface

// File: rtl/rev_datapath_seq.sv
// Reversible register-file datapath: each command runs IDLE -> EXEC -> WB, and
// DIR=1 applies the exact inverse of the forward op so sequences can be undone.
module rev_datapath_seq #(
  parameter int WIDTH  = 12,
  parameter int NREG   = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  rev_datapath_seq_if.slave cmd
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_XOR, OP_SWAP, OP_XLD, OP_JMP, OP_BAD
  } op_e;

  state_e            state_q;
  op_e               op_q;
  logic              dir_q;
  logic [RW-1:0]     rd_q, rs_q;
  logic              cin_q;
  logic [WIDTH-1:0]  din_q;
  logic [WIDTH-1:0]  regs_q [NREG];
  logic [ADDR_W-1:0] pc_q, pc_res_q;
  logic [WIDTH-1:0]  dout_q, res_q, swap_q;
  logic              cy_q, rej_q, ovf_q, done_q, err_q, ready_q;

  logic [WIDTH-1:0]  a, b, res_d, swap_d;
  logic [WIDTH:0]    sum, dif;
  logic              do_add, cy_d, rej_d;
  logic [ADDR_W-1:0] step, pc_d;
  logic              wr_rd, is_arith;

  // EXEC-stage arithmetic on the latched command; captured into *_q at the EXEC edge.
  always_comb begin
    a        = regs_q[rd_q];
    b        = regs_q[rs_q];
    sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_q};
    dif      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_q};
    do_add   = (op_q == OP_ADD) ^ dir_q;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    res_d    = a;
    swap_d   = b;
    cy_d     = 1'b0;
    unique case (op_q)
      OP_ADD, OP_SUB: begin
        res_d = do_add ? sum[WIDTH-1:0] : dif[WIDTH-1:0];
        cy_d  = do_add ? sum[WIDTH] : dif[WIDTH];
      end
      OP_XOR:  res_d = a ^ b;
      OP_SWAP: begin
        res_d  = b;
        swap_d = a;
      end
      OP_XLD:  res_d = a ^ din_q;
      default: ;
    endcase
    rej_d    = (op_q == OP_BAD) ||
               ((op_q inside {OP_ADD, OP_SUB, OP_XOR}) && (rd_q == rs_q));
    step     = (op_q == OP_JMP) ? ADDR_W'(din_q) : ADDR_W'(1);
    pc_d     = dir_q ? (pc_q - step) : (pc_q + step);
    wr_rd    = op_q inside {OP_ADD, OP_SUB, OP_XOR, OP_SWAP, OP_XLD};
    is_arith = op_q inside {OP_ADD, OP_SUB};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      dir_q    <= 1'b0;
      rd_q     <= '0;
      rs_q     <= '0;
      cin_q    <= 1'b0;
      din_q    <= '0;
      pc_q     <= '0;
      pc_res_q <= '0;
      dout_q   <= '0;
      res_q    <= '0;
      swap_q   <= '0;
      cy_q     <= 1'b0;
      rej_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      // NOTE: the register file is small and must read back as zero after reset, so it is reset explicitly.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q    <= op_e'(cmd.op);
            dir_q   <= cmd.dir;
            rd_q    <= cmd.rd;
            rs_q    <= cmd.rs;
            cin_q   <= cmd.cin;
            din_q   <= cmd.data_in;
            ready_q <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q    <= res_d;
          swap_q   <= swap_d;
          cy_q     <= cy_d;
          rej_q    <= rej_d;
          pc_res_q <= pc_d;
          state_q  <= S_WB;
        end
        S_WB: begin
          if (rej_q) begin
            err_q <= 1'b1;
          end else begin
            done_q <= 1'b1;
            pc_q   <= pc_res_q;
            if (wr_rd) begin
              // SWAP with rd==rs writes the same value twice, which is the intended no-op.
              if (op_q == OP_SWAP) regs_q[rs_q] <= swap_q;
              regs_q[rd_q] <= res_q;
              dout_q       <= res_q;
            end
            if (is_arith) ovf_q <= cy_q;
          end
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.data_out  = dout_q;
  assign cmd.addr_out  = pc_q;
  assign cmd.ovf       = ovf_q;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
endmodule

// File: tb/tb_rev_datapath_seq.sv
// Scoreboard bench for rev_datapath_seq: a behavioural model predicts each
// command's outcome, a monitor compares whenever DONE or ERR pulses.
module tb_rev_datapath_seq;
  localparam int W   = 12;
  localparam int N   = 4;
  localparam int A   = 12;
  localparam int MOD = 1 << W;
  localparam int PMOD = 1 << A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rev_datapath_seq_if #(.WIDTH(W), .NREG(N), .ADDR_W(A)) bus ();

  rev_datapath_seq #(.WIDTH(W), .NREG(N), .ADDR_W(A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (bus.slave)
  );

  typedef struct {
    bit err;
    int dout;
    int pc;
    bit ovf;
    int cyc;
  } exp_t;

  typedef struct {
    int op, rd, rs, cin, din;
  } cmd_t;

  exp_t sb[$];
  cmd_t hist[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_reg[N];
  int m_pc, m_dout;
  bit m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = 0;
    m_pc = 0; m_dout = 0; m_ovf = 0;
  endfunction

  // Applies one command to the model using the plain arithmetic rules.
  function automatic bit model_apply(input int op, input int dir, input int rd,
                                     input int rs, input int cin, input int din);
    int a, b, r, step;
    bit add, rej;
    a   = m_reg[rd];
    b   = m_reg[rs];
    rej = (op == 7) || ((op >= 1 && op <= 3) && rd == rs);
    if (rej) return 1'b1;
    case (op)
      1, 2: begin
        add    = (op == 1) != (dir == 1);
        r      = add ? a + b + cin : a - b - cin;
        m_ovf  = add ? (r >= MOD) : (r < 0);
        r      = wrap(r, MOD);
        m_reg[rd] = r; m_dout = r;
      end
      3: begin m_reg[rd] = a ^ b; m_dout = a ^ b; end
      4: begin m_reg[rd] = b; m_reg[rs] = a; m_dout = b; end
      5: begin m_reg[rd] = a ^ (din % MOD); m_dout = m_reg[rd]; end
      default: ;
    endcase
    step = (op == 6) ? (din % PMOD) : 1;
    m_pc = wrap(dir ? m_pc - step : m_pc + step, PMOD);
    return 1'b0;
  endfunction

  task automatic send(input int op, input int dir, input int rd, input int rs,
                      input int cin, input int din);
    exp_t e;
    int   t;
    @(negedge clk);
    t = 0;
    while (!bus.cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) check("ready_timeout", 0, 1);
    e.err  = model_apply(op, dir, rd, rs, cin, din);
    e.dout = m_dout;
    e.pc   = m_pc;
    e.ovf  = m_ovf;
    e.cyc  = cyc;
    sb.push_back(e);
    bus.op        = 3'(op);
    bus.dir       = dir[0];
    bus.rd        = 2'(rd);
    bus.rs        = 2'(rs);
    bus.cin       = cin[0];
    bus.data_in   = W'(din);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.done || bus.err) && t < 10);
    if (!(bus.done || bus.err)) check("completion_timeout", 0, 1);
  endtask

  // Monitor: any DONE/ERR pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.done || bus.err)) begin
      check("done_err_exclusive", {31'b0, bus.done && bus.err}, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        check("err_flag", {31'b0, bus.err}, {31'b0, e.err});
        check("data_out", {20'b0, bus.data_out}, e.dout);
        check("addr_out", {20'b0, bus.addr_out}, e.pc);
        check("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
        check("latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input int rd, input int val);
    send(5, 0, rd, 0, 0, m_reg[rd] ^ val);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    bus.cmd_valid = 1'b0; bus.op = '0; bus.dir = 1'b0; bus.rd = '0;
    bus.rs = '0; bus.cin = 1'b0; bus.data_in = '0;
    model_reset();
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_ready", {31'b0, bus.cmd_ready}, 1);
    check("rst_done", {31'b0, bus.done}, 0);
    check("rst_err", {31'b0, bus.err}, 0);
    check("rst_dout", {20'b0, bus.data_out}, 0);
    check("rst_pc", {20'b0, bus.addr_out}, 0);
    check("rst_ovf", {31'b0, bus.ovf}, 0);

    // ADD forward with carry-in
    load(1, 5);
    load(2, 7);
    send(1, 0, 1, 2, 1, 0);
    check("t1_dout", {20'b0, bus.data_out}, 13);
    check("t1_ovf", {31'b0, bus.ovf}, 0);

    // Carry out and its exact undo
    load(1, 12'hFFF);
    load(2, 1);
    send(1, 0, 1, 2, 0, 0);
    check("t2_fwd_dout", {20'b0, bus.data_out}, 0);
    check("t2_fwd_ovf", {31'b0, bus.ovf}, 1);
    send(1, 1, 1, 2, 0, 0);
    check("t2_rev_dout", {20'b0, bus.data_out}, 12'hFFF);
    check("t2_rev_ovf", {31'b0, bus.ovf}, 1);

    // Reversibility guard, then a normal command
    send(3, 0, 2, 2, 0, 0);
    send(0, 0, 0, 0, 0, 0);

    // Reset in the middle of an ADD
    @(negedge clk);
    bus.op = 3'd1; bus.dir = 1'b0; bus.rd = 2'd1; bus.rs = 2'd2; bus.cin = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_ready_in_rst", {31'b0, bus.cmd_ready}, 1);
    check("t6_pc", {20'b0, bus.addr_out}, 0);
    check("t6_ovf", {31'b0, bus.ovf}, 0);
    check("t6_dout", {20'b0, bus.data_out}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("t6_no_done", {31'b0, seen_done}, 0);
    check("t6_ready_after", {31'b0, bus.cmd_ready}, 1);
    for (int r = 0; r < N; r++) send(4, 0, r, r, 0, 0);

    // PC wrap and JMP (start from PC=0)
    do_reset();
    send(0, 1, 0, 0, 0, 0);
    check("t4_nop_rev_pc", {20'b0, bus.addr_out}, 12'hFFF);
    send(6, 0, 0, 0, 0, 12'h010);
    check("t4_jmp_pc", {20'b0, bus.addr_out}, 12'h00F);

    // Random forward run, then exact reverse replay
    do_reset();
    for (int i = 0; i < 200; i++) begin
      cmd_t c;
      c.op  = int'($urandom_range(0, 7));
      c.rd  = int'($urandom_range(0, N - 1));
      c.rs  = int'($urandom_range(0, N - 1));
      c.cin = int'($urandom_range(0, 1));
      c.din = int'($urandom_range(0, MOD - 1));
      hist.push_back(c);
      send(c.op, 0, c.rd, c.rs, c.cin, c.din);
    end
    while (hist.size() > 0) begin
      cmd_t c;
      c = hist.pop_back();
      send(c.op, 1, c.rd, c.rs, c.cin, c.din);
    end
    check("t5_pc_restored", {20'b0, bus.addr_out}, 0);
    for (int r = 0; r < N; r++) begin
      send(4, 0, r, r, 0, 0);
      check("t5_reg_restored", {20'b0, bus.data_out}, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
